// File: rtl/arb_req_queue_pkg.sv
// ---------------------------------------------------------------------------
// arb_req_q_pkg
//   Shared defaults and types for the arbiter request queue (arb_req_queue)
//   and its per-channel FIFO (arb_req_fifo).
//   Contents:
//     NUM_REQ_DFLT  default channel count (matches the arbiter width)
//     DATA_W_DFLT   default payload width
//     DEPTH_DFLT    default entries per channel FIFO (power of two, >= 2)
//     IDX_W         width of a binary channel index
//     data_t        payload word type
//     idx_t         channel index type
// ---------------------------------------------------------------------------
package arb_req_q_pkg;

   localparam int NUM_REQ_DFLT = 4;
   localparam int DATA_W_DFLT  = 8;
   localparam int DEPTH_DFLT   = 4;

   localparam int IDX_W = $clog2(NUM_REQ_DFLT);

   typedef logic [DATA_W_DFLT-1:0] data_t;
   typedef logic [IDX_W-1:0]       idx_t;

endpackage

// File: rtl/arb_req_queue_fifo.sv
// ---------------------------------------------------------------------------
// arb_req_fifo
//   Single-clock synchronous FIFO used as one channel buffer in front of the
//   round-robin arbiter. The head word is presented combinationally so a pop
//   can load it into the output register on the same edge that advances
//   rd_ptr. A push is accepted only when the FIFO is not full, regardless of
//   a simultaneous pop; a pop is accepted only when it is not empty.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset (pointers and count only)
//     push   in   write request
//     pop    in   read/advance request
//     wdata  in   DATA_W word to write
//     rdata  out  DATA_W head word (valid while !empty)
//     full   out  count == DEPTH, from registered count
//     empty  out  count == 0, from registered count
// ---------------------------------------------------------------------------
module arb_req_fifo
   import arb_req_q_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int DEPTH  = DEPTH_DFLT
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset: stale words are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/arb_req_queue.sv
// ---------------------------------------------------------------------------
// arb_req_queue
//   Per-requester input buffering directly upstream of round_robin_arb.
//   Each of NUM_REQ valid/ready channels feeds its own DEPTH-entry FIFO; a
//   non-empty FIFO raises its request bit. The arbiter's grant/index pops
//   the head of the selected FIFO into one registered valid/ready output
//   stage tagged with the source channel.
//   Optional build macro: ARB_REQ_Q_ERR_EN adds a sticky err output that
//   flags malformed grants and grants aimed at empty FIFOs.
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   NUM_REQ per-channel push strobes
//     in_data    in   NUM_REQ*DATA_W payloads, channel i at [i*DATA_W +: DATA_W]
//     in_ready   out  NUM_REQ per-channel not-full
//     request    out  NUM_REQ to arbiter, bit i = FIFO i non-empty
//     grant      in   NUM_REQ from arbiter, one-hot or zero
//     index      in   IDX_W binary encoding of grant
//     out_valid  out  output register holds data
//     out_data   out  DATA_W popped payload
//     out_src    out  IDX_W source channel of out_data
//     out_ready  in   downstream accept
//     err        out  sticky protocol error (ARB_REQ_Q_ERR_EN only)
// ---------------------------------------------------------------------------
module arb_req_queue
   import arb_req_q_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DFLT,
   parameter  int DATA_W  = DATA_W_DFLT,
   parameter  int DEPTH   = DEPTH_DFLT,
   localparam int IDX_W   = $clog2(NUM_REQ)
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        in_valid,
   input  logic [NUM_REQ*DATA_W-1:0] in_data,
   output logic [NUM_REQ-1:0]        in_ready,
   output logic [NUM_REQ-1:0]        request,
   input  logic [NUM_REQ-1:0]        grant,
   input  logic [IDX_W-1:0]          index,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [IDX_W-1:0]          out_src,
   input  logic                      out_ready
`ifdef ARB_REQ_Q_ERR_EN
   ,
   output logic                      err
`endif
);

   logic [NUM_REQ-1:0] push_vec;
   logic [NUM_REQ-1:0] pop_vec;
   logic [NUM_REQ-1:0] full_vec;
   logic [NUM_REQ-1:0] empty_vec;
   logic [DATA_W-1:0]  head [NUM_REQ];

   logic               grant_any;
   logic               grant_seen;
   logic               grant_multi;
   logic               sel_grant;
   logic               sel_empty;
   logic [DATA_W-1:0]  sel_data;
   logic               can_load;
   logic               pop_en;

   // ---------------------------------------------------------------------
   // Channel FIFOs
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_chan
         // in_ready comes from registered state only, so a full FIFO
         // refuses a push even in the cycle it is being popped.
         assign push_vec[gi] = in_valid[gi] && !full_vec[gi];
         assign pop_vec[gi]  = pop_en && (index == IDX_W'(gi));

         arb_req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_vec[gi]),
            .pop   (pop_vec[gi]),
            .wdata (in_data[gi*DATA_W +: DATA_W]),
            .rdata (head[gi]),
            .full  (full_vec[gi]),
            .empty (empty_vec[gi])
         );
      end
   endgenerate

   assign in_ready = ~full_vec;
   assign request  = ~empty_vec;

   // ---------------------------------------------------------------------
   // Grant decode and pop select
   // ---------------------------------------------------------------------
   // The channel is chosen by index; grant must agree with it and be
   // one-hot, otherwise the grant is ignored. An index beyond NUM_REQ
   // matches nothing and is likewise ignored.
   always_comb begin
      grant_seen  = 1'b0;
      grant_multi = 1'b0;
      sel_grant   = 1'b0;
      sel_empty   = 1'b1;
      sel_data    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            if (grant_seen) grant_multi = 1'b1;
            grant_seen = 1'b1;
         end
         if (index == IDX_W'(i)) begin
            sel_grant = grant[i];
            sel_empty = empty_vec[i];
            sel_data  = head[i];
         end
      end
   end

   assign grant_any = |grant;
   assign can_load  = !out_valid || out_ready;
   assign pop_en    = grant_any && !grant_multi && sel_grant && !sel_empty && can_load;

   // ---------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------
   // A pop while the held word is being accepted replaces it directly, so
   // back-to-back pops stream without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (pop_en) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_src   <= index;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ARB_REQ_Q_ERR_EN
   // ---------------------------------------------------------------------
   // Protocol checker: sticky until reset; offending grants are still
   // ignored by the pop logic above.
   // ---------------------------------------------------------------------
   logic err_set;

   assign err_set = grant_multi
                 || (grant_any && !sel_grant)
                 || ((grant & empty_vec) != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// ---------------------------------------------------------------------------
// tb_arb_req_queue
//   Table-driven bench for arb_req_queue. Each table row is one clock of
//   stimulus with the expected request/in_ready/out_valid after the edge.
//   Payloads are tracked by per-channel model queues; each expected pop
//   moves the model head into a scoreboard queue that is compared when the
//   DUT presents the word. Build with ARB_REQ_Q_ERR_EN to also check err.
// ---------------------------------------------------------------------------
module tb_arb_req_queue;

   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   in_valid;
   logic [NR*DW-1:0] in_data;
   logic [NR-1:0]   in_ready;
   logic [NR-1:0]   request;
   logic [NR-1:0]   grant;
   logic [1:0]      index;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_src;
   logic            out_ready;
`ifdef ARB_REQ_Q_ERR_EN
   logic            err;
`endif

   always #5 clk = ~clk;

   arb_req_queue #(
      .NUM_REQ (NR),
      .DATA_W  (DW),
      .DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .request   (request),
      .grant     (grant),
      .index     (index),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
`ifdef ARB_REQ_Q_ERR_EN
      ,
      .err       (err)
`endif
   );

   typedef struct {
      logic [3:0]  in_valid;
      logic [31:0] in_data;
      logic [3:0]  grant;
      logic [1:0]  index;
      logic        out_ready;
      logic [3:0]  exp_request;
      logic [3:0]  exp_in_ready;
      logic        exp_out_valid;
      logic        exp_pop;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 22;
   vec_t vt [NVEC];

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] chq [NR][$];   // model contents per channel
   logic [9:0] sbq [$];       // expected {src, data} of pops in flight
   logic [9:0] last_word;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one row, update the model, clock once and compare after the edge.
   task automatic apply(input int n, input vec_t v);
      logic [NR-1:0] full_pre;
      logic [9:0]    exp_word;
      in_valid  = v.in_valid;
      in_data   = v.in_data;
      grant     = v.grant;
      index     = v.index;
      out_ready = v.out_ready;
      for (int i = 0; i < NR; i++) full_pre[i] = (chq[i].size() >= DEPTH);
      if (v.exp_pop) begin
         if (chq[v.index].size() == 0) begin
            chk("model_has_data", 32'(0), 32'(1));
         end else begin
            sbq.push_back({v.index, chq[v.index].pop_front()});
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (v.in_valid[i] && !full_pre[i]) chq[i].push_back(v.in_data[i*8 +: 8]);
      end
      @(posedge clk);
      #1;
      $display("vec %0d: in_valid=%b grant=%b index=%0d out_ready=%b -> request=%b in_ready=%b out_valid=%b out_data=%h out_src=%0d",
               n, v.in_valid, v.grant, v.index, v.out_ready, request, in_ready, out_valid, out_data, out_src);
      chk("request",   32'(request),   32'(v.exp_request));
      chk("in_ready",  32'(in_ready),  32'(v.exp_in_ready));
      chk("out_valid", 32'(out_valid), 32'(v.exp_out_valid));
      if (v.exp_pop) begin
         if (sbq.size() == 0) begin
            chk("scoreboard_nonempty", 32'(0), 32'(1));
         end else begin
            exp_word = sbq.pop_front();
            chk("out_data", 32'(out_data), 32'(exp_word[7:0]));
            chk("out_src",  32'(out_src),  32'(exp_word[9:8]));
            last_word = exp_word;
         end
      end else if (v.exp_out_valid) begin
         chk("out_data_hold", 32'(out_data), 32'(last_word[7:0]));
         chk("out_src_hold",  32'(out_src),  32'(last_word[9:8]));
      end
`ifdef ARB_REQ_Q_ERR_EN
      chk("err", 32'(err), 32'(v.exp_err));
`endif
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_request"},   32'(request),   32'(0));
      chk({tag, "_in_ready"},  32'(in_ready),  32'(4'hF));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
      chk({tag, "_out_data"},  32'(out_data),  32'(0));
      chk({tag, "_out_src"},   32'(out_src),   32'(0));
`ifdef ARB_REQ_Q_ERR_EN
      chk({tag, "_err"},       32'(err),       32'(0));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v_end;
      //            in_valid in_data       grant   idx   ordy  req      rdy      ov    pop   err
      vt[0]  = '{4'b1101, 32'hD3C200A0, 4'b0000, 2'd0, 1'b1, 4'b1101, 4'hF, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{4'b0000, 32'h00000000, 4'b0001, 2'd0, 1'b1, 4'b1100, 4'hF, 1'b1, 1'b1, 1'b0};
      vt[2]  = '{4'b0100, 32'h00210000, 4'b0000, 2'd0, 1'b1, 4'b1100, 4'hF, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{4'b0100, 32'h00220000, 4'b0000, 2'd0, 1'b0, 4'b1100, 4'hF, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{4'b0100, 32'h00230000, 4'b0000, 2'd0, 1'b0, 4'b1100, 4'hB, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{4'b0100, 32'h00240000, 4'b0000, 2'd0, 1'b0, 4'b1100, 4'hB, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{4'b0100, 32'h00250000, 4'b0100, 2'd2, 1'b1, 4'b1100, 4'hF, 1'b1, 1'b1, 1'b0};
      vt[7]  = '{4'b0000, 32'h00000000, 4'b0100, 2'd2, 1'b0, 4'b1100, 4'hF, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{4'b0000, 32'h00000000, 4'b0100, 2'd2, 1'b1, 4'b1100, 4'hF, 1'b1, 1'b1, 1'b0};
      vt[9]  = '{4'b0000, 32'h00000000, 4'b0100, 2'd2, 1'b1, 4'b1100, 4'hF, 1'b1, 1'b1, 1'b0};
      vt[10] = '{4'b0000, 32'h00000000, 4'b0100, 2'd2, 1'b1, 4'b1000, 4'hF, 1'b1, 1'b1, 1'b0};
      vt[11] = '{4'b0100, 32'h00260000, 4'b0000, 2'd0, 1'b1, 4'b1100, 4'hF, 1'b0, 1'b0, 1'b0};
      vt[12] = '{4'b0000, 32'h00000000, 4'b0100, 2'd2, 1'b1, 4'b1000, 4'hF, 1'b1, 1'b1, 1'b0};
      vt[13] = '{4'b1000, 32'h31000000, 4'b0000, 2'd0, 1'b1, 4'b1000, 4'hF, 1'b0, 1'b0, 1'b0};
      vt[14] = '{4'b1000, 32'h32000000, 4'b1000, 2'd3, 1'b1, 4'b1000, 4'hF, 1'b1, 1'b1, 1'b0};
      vt[15] = '{4'b0000, 32'h00000000, 4'b0010, 2'd1, 1'b1, 4'b1000, 4'hF, 1'b0, 1'b0, 1'b1};
      vt[16] = '{4'b0000, 32'h00000000, 4'b1000, 2'd3, 1'b1, 4'b1000, 4'hF, 1'b1, 1'b1, 1'b1};
      vt[17] = '{4'b0000, 32'h00000000, 4'b1000, 2'd3, 1'b1, 4'b0000, 4'hF, 1'b1, 1'b1, 1'b1};
      vt[18] = '{4'b1111, 32'h44434241, 4'b0000, 2'd0, 1'b1, 4'b1111, 4'hF, 1'b0, 1'b0, 1'b1};
      vt[19] = '{4'b0000, 32'h00000000, 4'b0110, 2'd1, 1'b1, 4'b1111, 4'hF, 1'b0, 1'b0, 1'b1};
      vt[20] = '{4'b0000, 32'h00000000, 4'b0001, 2'd2, 1'b1, 4'b1111, 4'hF, 1'b0, 1'b0, 1'b1};
      vt[21] = '{4'b0000, 32'h00000000, 4'b0001, 2'd0, 1'b1, 4'b1110, 4'hF, 1'b1, 1'b1, 1'b1};

      last_word = '0;
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      grant     = '0;
      index     = '0;
      out_ready = 1'b0;

      // Reset state, checked while reset is still held.
      repeat (2) @(posedge clk);
      #1;
      $display("reset: request=%b in_ready=%b out_valid=%b", request, in_ready, out_valid);
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < NVEC; n++) apply(n, vt[n]);

      // Asynchronous reset mid-stream: out_valid is 1 and channels 1..3
      // hold data. Assert reset between edges and check immediately.
      in_valid = 4'b0001;
      in_data  = 32'h00000055;
      grant    = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset: request=%b in_ready=%b out_valid=%b out_data=%h", request, in_ready, out_valid, out_data);
      check_reset_state("async_reset");
      in_valid = '0;
      in_data  = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++) chq[i].delete();
      sbq.delete();

      // After reset no buffered data survives: a grant to ch0 finds it empty.
      v_end = '{4'b0000, 32'h00000000, 4'b0001, 2'd0, 1'b1, 4'b0000, 4'hF, 1'b0, 1'b0, 1'b1};
      apply(NVEC, v_end);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
